// File: rtl/wb_csr_responder.sv
// wb_csr_responder: Wishbone classic target exposing GPIO and counter/compare CSRs.
module wb_csr_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          ADDR_BITS   = 8,
   parameter int          WAIT_STATES = 0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_oeb,
   output logic        irq_o
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
   localparam logic [2:0] LP_WLAST = 3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
   state_t      r_state, w_state_nxt;
   logic [2:0]  r_wcnt;
   logic [31:0] r_sync1, r_sync2, r_gpio_out, r_gpio_oeb, r_count, r_cmp, r_dat;
   logic        r_cnt_en, r_irq_en, r_match, r_irq;
   logic        w_cs, w_hit, w_go, w_wr, w_clr, w_w1c, w_set, w_unused;
   logic [31:0] w_off, w_rd, w_mask;
   logic [7:0]  w_we;
   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] mask,
                                           input logic [31:0] dat);
      return (old & ~mask) | (dat & mask);
   endfunction
   assign w_cs     = wbs_cyc_i & wbs_stb_i;
   assign w_hit    = w_cs & (wbs_adr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
   assign w_off    = 32'(wbs_adr_i[ADDR_BITS-1:2]);
   assign w_mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign w_wr     = w_go & wbs_we_i;
   assign w_we     = w_wr ? (8'd1 << w_off) : 8'd0;
   assign w_clr    = w_we[0] & wbs_sel_i[0] & wbs_dat_i[1];
   assign w_w1c    = w_we[6] & wbs_sel_i[0] & wbs_dat_i[0];
   assign w_set    = r_cnt_en & (r_count == r_cmp);
   assign w_unused = &{1'b0, wbs_adr_i[1:0]};
   // w_go marks the edge that raises ack: writes commit and read data is captured there
   always_comb begin
      w_state_nxt = r_state;
      w_go        = 1'b0;
      case (r_state)
         S_IDLE: if (w_hit) begin
            w_state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            w_go        = (WAIT_STATES == 0);
         end
         S_WAIT: if (!w_cs) w_state_nxt = S_IDLE;
            else if (r_wcnt == LP_WLAST) begin
               w_state_nxt = S_ACK;
               w_go        = 1'b1;
            end
         default: w_state_nxt = S_IDLE;
      endcase
   end
   always_comb begin
      w_rd = 32'h0;
      case (w_off)
         32'd0:   w_rd = {29'h0, r_irq_en, 1'b0, r_cnt_en};
         32'd1:   w_rd = r_gpio_out;
         32'd2:   w_rd = r_gpio_oeb;
         32'd3:   w_rd = r_sync2;
         32'd4:   w_rd = r_count;
         32'd5:   w_rd = r_cmp;
         32'd6:   w_rd = {31'h0, r_match};
         default: w_rd = 32'h0;
      endcase
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state    <= S_IDLE;
         r_wcnt     <= 3'd0;
         r_sync1    <= 32'h0;
         r_sync2    <= 32'h0;
         r_dat      <= 32'h0;
         r_gpio_out <= 32'h0;
         r_gpio_oeb <= 32'hFFFF_FFFF;
         r_count    <= 32'h0;
         r_cmp      <= 32'h0;
         r_cnt_en   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_match    <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wcnt     <= (r_state == S_WAIT) ? r_wcnt + 3'd1 : 3'd0;
         r_sync1    <= gpio_in;
         r_sync2    <= r_sync1;
         r_dat      <= w_go ? w_rd : 32'h0;
         if (w_we[0] && wbs_sel_i[0]) begin
            r_cnt_en <= wbs_dat_i[0];
            r_irq_en <= wbs_dat_i[2];
         end
         if (w_we[1]) r_gpio_out <= f_merge(r_gpio_out, w_mask, wbs_dat_i);
         if (w_we[2]) r_gpio_oeb <= f_merge(r_gpio_oeb, w_mask, wbs_dat_i);
         if (w_we[5]) r_cmp <= f_merge(r_cmp, w_mask, wbs_dat_i);
         r_count    <= w_clr ? 32'h0 : w_we[4] ? f_merge(r_count, w_mask, wbs_dat_i) :
                       r_cnt_en ? r_count + 32'd1 : r_count;
         r_match    <= w_set | (r_match & ~w_w1c);
         r_irq      <= r_match & r_irq_en;
      end
   end
   assign wbs_ack_o = (r_state == S_ACK);
   assign wbs_dat_o = r_dat;
   assign gpio_out  = r_gpio_out;
   assign gpio_oeb  = r_gpio_oeb;
   assign irq_o     = r_irq;
endmodule

// File: tb/tb_wb_csr_responder.sv
// tb_wb_csr_responder: randomized and directed checks of two responders (0 and 3 wait states).
module tb_wb_csr_responder;
   localparam logic [31:0] BASE = 32'h3000_0000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   logic        rst_n[2], cyc[2], stb[2], we[2], ack[2], irq[2];
   logic [3:0]  sel[2];
   logic [31:0] adr[2], wdat[2], rdat[2], gout[2], goeb[2];
   logic [31:0] gin;
   int checks = 0, failures = 0, ack_cyc = 0;
   logic [31:0] m_out[2], m_oeb[2], m_cnt[2], m_cmp[2];
   logic        m_en[2], m_ien[2], m_match[2];
   wb_csr_responder #(.WAIT_STATES(0)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_n(rst_n[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
      .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]),
      .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]), .gpio_in(gin), .gpio_out(gout[0]),
      .gpio_oeb(goeb[0]), .irq_o(irq[0]));
   wb_csr_responder #(.WAIT_STATES(3)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_n(rst_n[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
      .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]),
      .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]), .gpio_in(gin), .gpio_out(gout[1]),
      .gpio_oeb(goeb[1]), .irq_o(irq[1]));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] bm(input logic [31:0] old, input logic [3:0] s,
                                      input logic [31:0] v);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = v[8*i +: 8];
      return r;
   endfunction
   function automatic int exp_lat(input int d);
      return (d == 0) ? 1 : 4;
   endfunction
   function automatic logic [31:0] mexp(input int d, input int off);
      case (off)
         0: return {29'h0, m_ien[d], 1'b0, m_en[d]};
         1: return m_out[d];
         2: return m_oeb[d];
         3: return gin;
         4: return m_cnt[d];
         5: return m_cmp[d];
         6: return {31'h0, m_match[d]};
         default: return 32'h0;
      endcase
   endfunction
   task automatic mreset(input int d);
      m_out[d] = 32'h0; m_oeb[d] = 32'hFFFF_FFFF; m_cnt[d] = 32'h0; m_cmp[d] = 32'h0;
      m_en[d] = 1'b0; m_ien[d] = 1'b0; m_match[d] = 1'b0;
   endtask
   task automatic mwrite(input int d, input int off, input logic [3:0] s, input logic [31:0] v);
      case (off)
         0: if (s[0]) begin
            m_en[d] = v[0]; m_ien[d] = v[2];
            if (v[1]) m_cnt[d] = 32'h0;
         end
         1: m_out[d] = bm(m_out[d], s, v);
         2: m_oeb[d] = bm(m_oeb[d], s, v);
         4: m_cnt[d] = bm(m_cnt[d], s, v);
         5: m_cmp[d] = bm(m_cmp[d], s, v);
         6: if (s[0] && v[0]) m_match[d] = 1'b0;
         default: ;
      endcase
   endtask
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] v, input int maxc, output logic [31:0] r, output int lat);
      logic got = 1'b0;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = v;
      r = 32'h0; lat = 0;
      for (int i = 1; i <= maxc && !got; i++) begin
         @(posedge clk); #1;
         if (ack[d]) begin
            got = 1'b1; lat = i; r = rdat[d]; ack_cyc = cyc_n;
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      if (got) begin
         @(posedge clk); #1;
         chk("ack_one_cycle", {31'h0, ack[d]}, 32'h0);
         chk("dat_zero_after_ack", rdat[d], 32'h0);
      end
   endtask
   task automatic wr(input int d, input int off, input logic [3:0] s, input logic [31:0] v);
      logic [31:0] r;
      int lat;
      mwrite(d, off, s, v);
      xfer(d, 1'b1, BASE + 32'(off * 4), s, v, 20, r, lat);
      chk("wr_lat", 32'(lat), 32'(exp_lat(d)));
   endtask
   task automatic rdx(input int d, input int off, input logic [31:0] e, input string tag);
      logic [31:0] r;
      int lat;
      xfer(d, 1'b0, BASE + 32'(off * 4), 4'hF, 32'h0, 20, r, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(d)));
      chk(tag, r, e);
   endtask
   task automatic rd(input int d, input int off, input string tag);
      rdx(d, off, mexp(d, off), tag);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      logic [31:0] r, v;
      logic [3:0]  s;
      int lat, off, e, icyc, acks;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
         sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
         mreset(d);
      end
      gin = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      chk("rst_ack", {31'h0, ack[0]}, 32'h0);
      chk("rst_dat", rdat[0], 32'h0);
      chk("rst_gpio_out", gout[0], 32'h0);
      chk("rst_gpio_oeb", goeb[0], 32'hFFFF_FFFF);
      chk("rst_irq", {31'h0, irq[0]}, 32'h0);
      rdx(0, 2, 32'hFFFF_FFFF, "oeb_reset");
      wr(0, 1, 4'b0101, 32'hA5A5_5A5A);
      rdx(0, 1, 32'h00A5_005A, "gpio_out_sel");
      chk("gpio_out_pin", gout[0], 32'h00A5_005A);
      gin = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      rdx(0, 3, 32'h1234_5678, "gpio_in");
      xfer(0, 1'b1, 32'h3000_1000, 4'hF, 32'hFFFF_FFFF, 20, r, lat);
      chk("miss_noack", 32'(lat), 32'h0);
      rd(0, 1, "miss_nochange");
      for (int i = 0; i < 80; i++) begin
         off = $urandom_range(0, 7);
         v   = $urandom;
         s   = 4'($urandom_range(0, 15));
         if (i % 16 == 0) begin
            gin = $urandom;
            repeat (3) @(posedge clk);
            #1;
         end
         if ($urandom_range(0, 5) == 0) begin
            xfer(0, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(1, 255) << 8) + 32'(off * 4),
                 s, v, 6, r, lat);
            chk("rnd_miss_noack", 32'(lat), 32'h0);
         end else if ($urandom_range(0, 1) == 1) begin
            if (off == 0) v[0] = 1'b0;
            wr(0, off, s, v);
         end else rd(0, off, "rnd_rd");
         chk("rnd_gpio_out", gout[0], m_out[0]);
         chk("rnd_gpio_oeb", goeb[0], m_oeb[0]);
      end
      wr(0, 0, 4'hF, 32'h2);
      rd(0, 4, "cnt_clr");
      wr(0, 4, 4'hF, 32'hFFFF_FFFE);
      wr(0, 5, 4'hF, 32'h0);
      wr(0, 6, 4'hF, 32'h1);
      rd(0, 6, "status_clear");
      wr(0, 0, 4'hF, 32'h5);
      e = ack_cyc;
      icyc = 0;
      for (int k = 0; k < 20 && icyc == 0; k++) begin
         @(posedge clk); #1;
         if (irq[0]) icyc = cyc_n;
      end
      chk("irq_delay", 32'(icyc - e), 32'd4);
      xfer(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 20, r, lat);
      chk("cnt_running", r, 32'hFFFF_FFFE + 32'(ack_cyc - 1 - e));
      rdx(0, 6, 32'h1, "match_sticky");
      chk("irq_held", {31'h0, irq[0]}, 32'h1);
      wr(0, 6, 4'h1, 32'h1);
      chk("irq_cleared", {31'h0, irq[0]}, 32'h0);
      rdx(0, 6, 32'h0, "match_w1c");
      wr(0, 0, 4'hF, 32'h2);
      rd(0, 4, "cnt_clr_stop");
      rdx(1, 0, 32'h0, "ws3_read");
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 32'h4;
      sel[1] = 4'hF; wdat[1] = 32'hDEAD_BEEF;
      acks = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack[1]) acks++;
      end
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (ack[1]) acks++;
      end
      chk("abort_noack", 32'(acks), 32'h0);
      rd(1, 1, "abort_nowrite");
      wr(1, 1, 4'hF, 32'h1111_2222);
      wr(1, 2, 4'hF, 32'h0);
      chk("ws3_gpio_oeb_pin", goeb[1], 32'h0);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = BASE; sel[1] = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      rst_n[1] = 1'b0;
      #1;
      chk("rst_wait_ack", {31'h0, ack[1]}, 32'h0);
      chk("rst_wait_gout", gout[1], 32'h0);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      mreset(1);
      rd(1, 2, "after_wait_rst_oeb");
      wr(1, 1, 4'hF, 32'hCAFE_0001);
      wr(1, 2, 4'hF, 32'h0000_FFFF);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 32'h14;
      sel[1] = 4'hF; wdat[1] = 32'h7777_7777;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_rst_ack", {31'h0, ack[1]}, 32'h1);
      rst_n[1] = 1'b0;
      #1;
      chk("rst_ack_drop", {31'h0, ack[1]}, 32'h0);
      chk("rst_ack_goeb", goeb[1], 32'hFFFF_FFFF);
      cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      mreset(1);
      for (int k = 0; k < 8; k++) rd(1, k, "post_rst_read");
      chk("post_rst_irq", {31'h0, irq[1]}, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
